dado_roller: RTL and testbench

Multi-die electronic dice roller with pip-display outputs. A roll request spins every non-held die through faces 1..6 for at least `ROLL_CYCLES` steps. On release the dice freeze and a one-cycle `done` pulse is raised. Each die drives its own seven-segment pip pattern. It sits between debounced push-button inputs and the LED pip arrays on the board.

---
 rtl/dado_roller.sv | 143 ++++++++++++++
 tb/tb_dado_roller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dado_roller.sv
// Multi-die electronic dice roller with seven-segment pip outputs.
// Optional registered running sum of all faces: define DADO_SUM_EN.
module dado_roller #(
  parameter int N_DICE      = 2,
  parameter int ROLL_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  roll,
  input  logic [N_DICE-1:0]     hold,
  output logic [3*N_DICE-1:0]   value,
  output logic [7*N_DICE-1:0]   pips,
  output logic                  busy,
  output logic                  done
`ifdef DADO_SUM_EN
  ,
  output logic [$clog2(6*N_DICE+1)-1:0] sum
`endif
);

  localparam int CW = $clog2(ROLL_CYCLES + 1);
  localparam logic [CW-1:0] RC = CW'(ROLL_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    SPIN = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3*N_DICE-1:0]  value_q, value_d;
  logic                 done_q, done_d;
  logic                 adv;

  function automatic logic [2:0] step(
    input logic [2:0] v,
    input int         s
  );
    logic [3:0] t;
    t = {1'b0, v} + 4'(s) - 4'd1;
    if (t >= 4'd6) t = t - 4'd6;
    return t[2:0] + 3'd1;
  endfunction

  function automatic logic [6:0] pip(input logic [2:0] v);
    logic [6:0] p;
    p = '0;
    if (v >= 3'd1 && v <= 3'd6) begin
      p[0] = (v >= 3'd2);
      p[6] = (v >= 3'd2);
      p[1] = (v >= 3'd4);
      p[5] = (v >= 3'd4);
      p[2] = (v == 3'd6);
      p[4] = (v == 3'd6);
      p[3] = v[0];
    end
    return p;
  endfunction

  // Next-state logic: decide whether this edge advances or completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (roll) begin
          state_d = SPIN;
          cnt_d   = '0;
        end
      end
      SPIN: begin
        if (roll || cnt_q != RC) begin
          adv = 1'b1;
          if (cnt_q != RC) cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Each non-held die steps by (index+1) faces on an advancing edge.
  always_comb begin
    value_d = value_q;
    for (int i = 0; i < N_DICE; i++) begin
      if (adv && !hold[i])
        value_d[3*i +: 3] = step(value_q[3*i +: 3], i + 1);
    end
  end

  // State, counter, dice and completion pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < N_DICE; i++)
        value_q[3*i +: 3] <= 3'd1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      value_q <= value_d;
    end
  end

  // Pip patterns decode straight from the registered faces.
  always_comb begin
    pips = '0;
    for (int i = 0; i < N_DICE; i++)
      pips[7*i +: 7] = pip(value_q[3*i +: 3]);
  end

  assign value = value_q;
  assign busy  = (state_q == SPIN);
  assign done  = done_q;

`ifdef DADO_SUM_EN
  localparam int SW = $clog2(6*N_DICE+1);

  logic [SW-1:0] sum_q, sum_d;

  // Total of the frozen faces, captured on the completion edge.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_DICE; i++)
      sum_d = sum_d + SW'(value_q[3*i +: 3]);
  end

  // Sum register holds between rolls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         sum_q <= SW'(N_DICE);
    else if (done_d) sum_q <= sum_d;
  end

  assign sum = sum_q;
`endif

endmodule

// File: tb/tb_dado_roller.sv
// Directed table-driven bench for dado_roller.
// N_DICE=2, ROLL_CYCLES=4.
module tb_dado_roller;

  logic       clk;
  logic       rst;
  logic       roll;
  logic [1:0] hold;
  logic [5:0] value;
  logic [13:0] pips;
  logic       busy;
  logic       done;
`ifdef DADO_SUM_EN
  logic [3:0] sum;
`endif

  int n_cmp;
  int n_bad;

  dado_roller #(
    .N_DICE(2),
    .ROLL_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .roll(roll),
    .hold(hold),
    .value(value),
    .pips(pips),
    .busy(busy),
    .done(done)
`ifdef DADO_SUM_EN
    ,
    .sum(sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       roll;
    logic [1:0] hold;
    logic       busy;
    logic       done;
    logic [2:0] v0;
    logic [2:0] v1;
  } vec_t;

  vec_t       tbl[$];
  logic [6:0] pipt[0:7];

  task automatic add(input logic r, input logic rl,
                     input logic [1:0] h, input logic b,
                     input logic d, input logic [2:0] v0,
                     input logic [2:0] v1);
    vec_t e;
    e.r = r; e.roll = rl; e.hold = h;
    e.busy = b; e.done = d; e.v0 = v0; e.v1 = v1;
    tbl.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse;
    rst = 1'b1;
    #2;
  endtask

  task automatic check_out(input string tag, input logic b,
                           input logic d, input logic [2:0] v0,
                           input logic [2:0] v1);
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".value"}, 32'(value), 32'({v1, v0}));
    check({tag, ".pips"}, 32'(pips), 32'({pipt[v1], pipt[v0]}));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    pipt[0] = 7'b0000000;
    pipt[1] = 7'b0001000;
    pipt[2] = 7'b1000001;
    pipt[3] = 7'b1001001;
    pipt[4] = 7'b1100011;
    pipt[5] = 7'b1101011;
    pipt[6] = 7'b1110111;
    pipt[7] = 7'b0000000;

    rst  = 1'b1;
    roll = 1'b0;
    hold = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_out("rst", 1'b0, 1'b0, 3'd1, 3'd1);
`ifdef DADO_SUM_EN
    check("rst.sum", 32'(sum), 32'd2);
`endif
    rst = 1'b0;

    // one-cycle roll
    add(0, 1, 2'b00, 1, 0, 1, 1);
    add(0, 0, 2'b00, 1, 0, 2, 3);
    add(0, 0, 2'b00, 1, 0, 3, 5);
    add(0, 0, 2'b00, 1, 0, 4, 1);
    add(0, 0, 2'b00, 1, 0, 5, 3);
    add(0, 0, 2'b00, 0, 1, 5, 3);
    add(0, 0, 2'b00, 0, 0, 5, 3);
    // hold die 1 throughout
    add(1, 0, 2'b10, 0, 0, 1, 1);
    add(0, 1, 2'b10, 1, 0, 1, 1);
    add(0, 0, 2'b10, 1, 0, 2, 1);
    add(0, 0, 2'b10, 1, 0, 3, 1);
    add(0, 0, 2'b10, 1, 0, 4, 1);
    add(0, 0, 2'b10, 1, 0, 5, 1);
    add(0, 0, 2'b10, 0, 1, 5, 1);
    add(0, 0, 2'b10, 0, 0, 5, 1);
    // long roll, 10 cycles
    add(1, 0, 2'b00, 0, 0, 1, 1);
    add(0, 1, 2'b00, 1, 0, 1, 1);
    add(0, 1, 2'b00, 1, 0, 2, 3);
    add(0, 1, 2'b00, 1, 0, 3, 5);
    add(0, 1, 2'b00, 1, 0, 4, 1);
    add(0, 1, 2'b00, 1, 0, 5, 3);
    add(0, 1, 2'b00, 1, 0, 6, 5);
    add(0, 1, 2'b00, 1, 0, 1, 1);
    add(0, 1, 2'b00, 1, 0, 2, 3);
    add(0, 1, 2'b00, 1, 0, 3, 5);
    add(0, 1, 2'b00, 1, 0, 4, 1);
    add(0, 0, 2'b00, 0, 1, 4, 1);
    add(0, 0, 2'b00, 0, 0, 4, 1);
    // reset in the middle of a spin
    add(1, 0, 2'b00, 0, 0, 1, 1);
    add(0, 1, 2'b00, 1, 0, 1, 1);
    add(0, 0, 2'b00, 1, 0, 2, 3);
    add(1, 0, 2'b00, 0, 0, 1, 1);
    add(0, 0, 2'b00, 0, 0, 1, 1);
    add(0, 0, 2'b00, 0, 0, 1, 1);
    add(0, 0, 2'b00, 0, 0, 1, 1);

    foreach (tbl[k]) begin
      string tag;
      tag = $sformatf("v%0d", k);
      roll = tbl[k].roll;
      hold = tbl[k].hold;
      if (tbl[k].r) begin
        rst_pulse();
        check_out(tag, tbl[k].busy, tbl[k].done,
                  tbl[k].v0, tbl[k].v1);
`ifdef DADO_SUM_EN
        check({tag, ".sum"}, 32'(sum), 32'd2);
`endif
        rst = 1'b0;
      end else begin
        tick();
        check_out(tag, tbl[k].busy, tbl[k].done,
                  tbl[k].v0, tbl[k].v1);
`ifdef DADO_SUM_EN
        if (tbl[k].done)
          check({tag, ".sum"}, 32'(sum),
                32'(tbl[k].v0) + 32'(tbl[k].v1));
`endif
      end
    end

    // back-to-back: roll again during the done cycle
    hold = 2'b00;
    roll = 1'b0;
    rst_pulse();
    rst = 1'b0;
    roll = 1'b1;
    tick();
    roll = 1'b0;
    repeat (5) tick();
    check_out("b2b.done1", 1'b0, 1'b1, 3'd5, 3'd3);
`ifdef DADO_SUM_EN
    check("b2b.sum1", 32'(sum), 32'd8);
`endif
    roll = 1'b1;
    tick();
    check_out("b2b.enter", 1'b1, 1'b0, 3'd5, 3'd3);
    roll = 1'b0;
    repeat (4) tick();
    check_out("b2b.last", 1'b1, 1'b0, 3'd3, 3'd5);
    tick();
    check_out("b2b.done2", 1'b0, 1'b1, 3'd3, 3'd5);
`ifdef DADO_SUM_EN
    check("b2b.sum2", 32'(sum), 32'd8);
`endif
    tick();
    check_out("b2b.idle", 1'b0, 1'b0, 3'd3, 3'd5);
`ifdef DADO_SUM_EN
    check("b2b.hold", 32'(sum), 32'd8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
